// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, access-mode and constant definitions for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IF_BUS = 2'd1,
        ST_D_BUS  = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam logic [2:0] MODE_WORD  = 3'b001;
    localparam logic [2:0] MODE_HALF  = 3'b010;
    localparam logic [2:0] MODE_BYTE  = 3'b011;
    localparam logic [2:0] MODE_UHALF = 3'b100;
    localparam logic [2:0] MODE_UBYTE = 3'b101;

    // Fetch result substituted when the memory never answers
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // A data access is legal when the mode is known and the address fits its size
    function automatic logic access_ok(input logic [2:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MODE_WORD:              return (addr_lo == 2'b00);
            MODE_HALF, MODE_UHALF:  return !addr_lo[0];
            MODE_BYTE, MODE_UBYTE:  return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and memory bus of the arbiter
interface mem_arbiter_if #(parameter int DATA_WIDTH = 32);
    logic                    if_req;
    logic [DATA_WIDTH-1:0]   if_addr;
    logic [DATA_WIDTH-1:0]   if_rdata;
    logic                    if_ready;
    logic                    d_req;
    logic                    d_we;
    logic [2:0]              d_mode;
    logic [DATA_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_ready;
    logic                    d_err;
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_mode, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lane_align.sv
// rtl/lane_align.sv - store lane steering/byte enables and load lane extraction/extension
module lane_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  i_st_mode,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_be,
    input  logic [2:0]  i_ld_mode,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Replicate narrow store data across lanes and enable only the addressed bytes
    always_comb begin
        o_st_wdata = i_st_wdata;
        o_st_be    = 4'b1111;
        case (i_st_mode)
            MODE_BYTE, MODE_UBYTE: begin
                o_st_wdata = {4{i_st_wdata[7:0]}};
                o_st_be    = 4'b0001 << i_st_addr_lo;
            end
            MODE_HALF, MODE_UHALF: begin
                o_st_wdata = {2{i_st_wdata[15:0]}};
                o_st_be    = 4'b0011 << i_st_addr_lo;
            end
            default: ;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it to 32 bits
    always_comb begin
        case (i_ld_addr_lo)
            2'd0:    w_byte = i_ld_rdata[7:0];
            2'd1:    w_byte = i_ld_rdata[15:8];
            2'd2:    w_byte = i_ld_rdata[23:16];
            default: w_byte = i_ld_rdata[31:24];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        case (i_ld_mode)
            MODE_BYTE:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            MODE_UBYTE: o_ld_data = {24'h0, w_byte};
            MODE_HALF:  o_ld_data = {{16{w_half[15]}}, w_half};
            MODE_UHALF: o_ld_data = {16'h0, w_half};
            default:    o_ld_data = i_ld_rdata;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch/data) single-port memory arbiter with timeout
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    arb_state_t            r_state;
    arb_state_t            w_next;
    logic                  r_last_data;
    logic                  r_is_data;
    logic                  r_err;
    logic                  r_we;
    logic [CW-1:0]         r_wait;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic [3:0]            r_be;
    logic [2:0]            r_mode;
    logic [1:0]            r_lo;
    logic                  w_d_ok;
    logic                  w_pick_data;
    logic                  w_pick_if;
    logic                  w_busy;
    logic                  w_timeout;
    logic [31:0]           w_st_wdata;
    logic [31:0]           w_ld_data;
    logic [3:0]            w_st_be;

    assign w_d_ok      = access_ok(bus.d_mode, bus.d_addr[1:0]);
    // On a tie the side that did not win last time is served
    assign w_pick_data = bus.d_req && !(bus.if_req && r_last_data);
    assign w_pick_if   = bus.if_req && !w_pick_data;
    assign w_busy      = (r_state == ST_IF_BUS) || (r_state == ST_D_BUS);
    assign w_timeout   = (r_wait == WAIT_LAST);

    lane_align u_lane_align (
        .i_st_mode    (bus.d_mode),
        .i_st_addr_lo (bus.d_addr[1:0]),
        .i_st_wdata   (bus.d_wdata),
        .o_st_wdata   (w_st_wdata),
        .o_st_be      (w_st_be),
        .i_ld_mode    (r_mode),
        .i_ld_addr_lo (r_lo),
        .i_ld_rdata   (bus.mem_rdata),
        .o_ld_data    (w_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: grant in IDLE, finish on ack or timeout, single response cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_data)    w_next = w_d_ok ? ST_D_BUS : ST_RESP;
                else if (w_pick_if) w_next = ST_IF_BUS;
            end
            ST_IF_BUS, ST_D_BUS: if (bus.mem_ack || w_timeout) w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture the granted access, count wait cycles and latch results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_data <= 1'b1;
            r_is_data   <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_wait      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_be        <= '0;
            r_mode      <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_data) begin
                        r_last_data <= 1'b1;
                        r_is_data   <= 1'b1;
                        r_err       <= !w_d_ok;
                        r_wait      <= '0;
                        r_addr      <= bus.d_addr & ~DATA_WIDTH'(3);
                        r_we        <= bus.d_we;
                        r_wdata     <= bus.d_we ? w_st_wdata : '0;
                        r_be        <= bus.d_we ? w_st_be : 4'hF;
                        r_mode      <= bus.d_mode;
                        r_lo        <= bus.d_addr[1:0];
                    end else if (w_pick_if) begin
                        r_last_data <= 1'b0;
                        r_is_data   <= 1'b0;
                        r_err       <= 1'b0;
                        r_wait      <= '0;
                        r_addr      <= bus.if_addr & ~DATA_WIDTH'(3);
                        r_we        <= 1'b0;
                        r_wdata     <= '0;
                        r_be        <= 4'hF;
                    end
                end
                ST_IF_BUS, ST_D_BUS: begin
                    if (bus.mem_ack) begin
                        if (r_is_data) r_d_rdata  <= w_ld_data;
                        else           r_if_rdata <= bus.mem_rdata;
                    end else if (w_timeout) begin
                        r_err <= r_is_data;
                        if (!r_is_data) r_if_rdata <= NOP_INSN;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and the captured access
    always_comb begin
        bus.mem_req   = w_busy;
        bus.mem_we    = r_we;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_be    = r_be;
        bus.if_rdata  = r_if_rdata;
        bus.d_rdata   = r_d_rdata;
        bus.if_ready  = (r_state == ST_RESP) && !r_is_data;
        bus.d_ready   = (r_state == ST_RESP) && r_is_data;
        bus.d_err     = (r_state == ST_RESP) && r_is_data && r_err;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cnt;
    logic saw;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic d_access(input string tag, input logic we, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] mrd, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_rd);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = we; bus.d_mode = mode; bus.d_addr = addr; bus.d_wdata = wdata;
        @(negedge clk);
        check({tag, ".mem_req"}, bus.mem_req, 1);
        check({tag, ".mem_addr"}, bus.mem_addr, exp_addr);
        check({tag, ".mem_we"}, bus.mem_we, we);
        check({tag, ".mem_be"}, bus.mem_be, exp_be);
        if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, exp_wdata);
        bus.mem_ack = 1'b1; bus.mem_rdata = mrd;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        check({tag, ".d_ready"}, bus.d_ready, 1);
        check({tag, ".d_err"}, bus.d_err, 0);
        if (!we) check({tag, ".d_rdata"}, bus.d_rdata, exp_rd);
        @(negedge clk);
        check({tag, ".d_ready_end"}, bus.d_ready, 0);
    endtask

    task automatic d_bad(input string tag, input logic [2:0] mode, input logic [31:0] addr);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = mode; bus.d_addr = addr;
        @(negedge clk);
        check({tag, ".mem_req"}, bus.mem_req, 0);
        check({tag, ".d_ready"}, bus.d_ready, 1);
        check({tag, ".d_err"}, bus.d_err, 1);
        bus.d_req = 1'b0;
        @(negedge clk);
        check({tag, ".d_ready_end"}, bus.d_ready, 0);
        check({tag, ".mem_req_end"}, bus.mem_req, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_mode = MODE_WORD; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.mem_req", bus.mem_req, 0);
        check("rst.if_ready", bus.if_ready, 0);
        check("rst.d_ready", bus.d_ready, 0);
        check("rst.d_err", bus.d_err, 0);
        check("rst.if_rdata", bus.if_rdata, 0);
        check("rst.d_rdata", bus.d_rdata, 0);
        check("rst.mem_be", bus.mem_be, 0);
        rst_n = 1'b1;

        // Tie after reset: fetch first, then data; zero-wait fetch timing
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = MODE_WORD; bus.d_addr = 32'h40;
        @(negedge clk);
        check("tie.mem_req", bus.mem_req, 1);
        check("tie.fetch_first", bus.mem_addr, 32'h100);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("tie.if_ready", bus.if_ready, 1);
        check("tie.d_ready_quiet", bus.d_ready, 0);
        check("tie.if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        bus.if_req = 1'b0;
        @(negedge clk);
        check("tie.idle_if_ready", bus.if_ready, 0);
        check("tie.idle_mem_req", bus.mem_req, 0);
        @(negedge clk);
        check("tie.data_second", bus.mem_addr, 32'h40);
        check("tie.data_mem_req", bus.mem_req, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        check("tie.d_ready", bus.d_ready, 1);
        check("tie.if_ready_quiet", bus.if_ready, 0);
        check("tie.d_rdata", bus.d_rdata, 32'h1122_3344);

        // Stray ack while idle must be ignored
        @(negedge clk);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_55AA;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("stray.d_ready", bus.d_ready, 0);
        check("stray.if_ready", bus.if_ready, 0);
        check("stray.d_rdata", bus.d_rdata, 32'h1122_3344);
        check("stray.if_rdata", bus.if_rdata, 32'hDEAD_BEEF);

        // Loads and stores with lane steering
        d_access("ld_b",  1'b0, MODE_BYTE,  32'h203, 32'h0, 32'h80FF_FFFF, 32'h200, 32'h0, 4'hF, 32'hFFFF_FF80);
        d_access("ld_bu", 1'b0, MODE_UBYTE, 32'h203, 32'h0, 32'h80FF_FFFF, 32'h200, 32'h0, 4'hF, 32'h0000_0080);
        d_access("ld_h",  1'b0, MODE_HALF,  32'h202, 32'h0, 32'h8001_1234, 32'h200, 32'h0, 4'hF, 32'hFFFF_8001);
        d_access("ld_hu", 1'b0, MODE_UHALF, 32'h200, 32'h0, 32'h8001_9234, 32'h200, 32'h0, 4'hF, 32'h0000_9234);
        d_access("st_h",  1'b1, MODE_HALF,  32'h102, 32'h1234_ABCD, 32'h0, 32'h100, 32'hABCD_ABCD, 4'hC, 32'h0);
        d_access("st_b",  1'b1, MODE_BYTE,  32'h301, 32'h0000_00A5, 32'h0, 32'h300, 32'hA5A5_A5A5, 4'h2, 32'h0);
        d_access("st_w",  1'b1, MODE_WORD,  32'h400, 32'hCAFE_F00D, 32'h0, 32'h400, 32'hCAFE_F00D, 4'hF, 32'h0);

        // Illegal accesses answer with an error and never touch memory
        d_bad("bad_word", MODE_WORD, 32'h101);
        d_bad("bad_half", MODE_HALF, 32'h203);
        d_bad("bad_mode", 3'b110, 32'h100);

        // Fetch whose requester drops mid-access still completes
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h8;
        @(negedge clk);
        check("drop.mem_req", bus.mem_req, 1);
        bus.if_req = 1'b0;
        @(negedge clk);
        check("drop.held", bus.mem_req, 1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("drop.if_ready", bus.if_ready, 1);

        // Tie after a fetch grant: data wins this time
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_mode = MODE_WORD; bus.d_addr = 32'h24; bus.d_wdata = 32'h77;
        @(negedge clk);
        check("tie2.data_first", bus.mem_addr, 32'h24);
        check("tie2.mem_we", bus.mem_we, 1);
        check("tie2.mem_wdata", bus.mem_wdata, 32'h77);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.d_req = 1'b0;
        check("tie2.d_ready", bus.d_ready, 1);
        check("tie2.if_quiet", bus.if_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check("tie2.fetch_second", bus.mem_addr, 32'h20);
        check("tie2.fetch_we", bus.mem_we, 0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.if_req = 1'b0;
        check("tie2.if_ready", bus.if_ready, 1);
        check("tie2.d_quiet", bus.d_ready, 0);
        check("tie2.if_rdata", bus.if_rdata, 32'hAAAA_5555);

        // Data timeout: no ack for the full wait budget
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = MODE_WORD; bus.d_addr = 32'h500;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.d_ready && cnt < 400);
        bus.d_req = 1'b0;
        check("to_d.latency", cnt, 256);
        check("to_d.d_err", bus.d_err, 1);

        // Fetch timeout returns a NOP
        @(negedge clk);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.if_ready && cnt < 400);
        bus.if_req = 1'b0;
        check("to_if.latency", cnt, 256);
        check("to_if.nop", bus.if_rdata, NOP_INSN);
        check("to_if.d_err", bus.d_err, 0);

        // Reset in the middle of an access
        @(negedge clk);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_mode = MODE_WORD; bus.d_addr = 32'h700;
        @(negedge clk);
        check("rst_mid.mem_req_before", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid.mem_req_drop", bus.mem_req, 0);
        bus.d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ready || bus.if_ready || bus.mem_req) saw = 1'b1;
        end
        check("rst_mid.no_ready", saw, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
